seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 115 +++++++++++
 tb/tb_seg_scan_mux.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit 7-segment scan multiplexer with frame-synchronous double buffering
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
module seg_scan_mux #(
   parameter int REFRESH_DIV  = 16,
   parameter int GUARD_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic [3:0]  hex_digit,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_start
);

   localparam logic [REFRESH_DIV-1:0] GUARD   = REFRESH_DIV'(GUARD_CYCLES);
   localparam logic [REFRESH_DIV-1:0] PRE_ONE = {{(REFRESH_DIV-1){1'b0}}, 1'b1};

   logic [REFRESH_DIV-1:0] presc_q, presc_d;
   logic [1:0]             idx_q, idx_d;
   logic [15:0]            pend_val_q, pend_val_d;
   logic [3:0]             pend_dp_q, pend_dp_d;
   logic                   pend_flag_q, pend_flag_d;
   logic [15:0]            disp_val_q, disp_val_d;
   logic [3:0]             disp_dp_q, disp_dp_d;
   logic [3:0]             hex_digit_q, hex_digit_d;
   logic [3:0]             an_q, an_d;
   logic                   dp_q, dp_d;
   logic                   frame_start_q, frame_start_d;

   logic       tick;
   logic       wrap;
   logic       active;
   logic [3:0] blank;

   always_comb begin
      tick          = &presc_q;
      wrap          = tick && (idx_q == 2'd3);
      presc_d       = presc_q + PRE_ONE;
      idx_d         = tick ? idx_q + 2'd1 : idx_q;
      pend_val_d    = pend_val_q;
      pend_dp_d     = pend_dp_q;
      pend_flag_d   = pend_flag_q;
      disp_val_d    = disp_val_q;
      disp_dp_d     = disp_dp_q;

      // Shadow only changes at the frame boundary; a coincident load bypasses pending.
      if (wrap) begin
         if (load) begin
            disp_val_d = value;
            disp_dp_d  = dp_in;
         end else if (pend_flag_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
         end
         pend_flag_d = 1'b0;
      end else if (load) begin
         pend_val_d  = value;
         pend_dp_d   = dp_in;
         pend_flag_d = 1'b1;
      end

      blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
      blank[3] = (disp_val_q[15:12] == 4'h0)   && !disp_dp_q[3];
      blank[2] = (disp_val_q[15:8]  == 8'h00)  && !disp_dp_q[2];
      blank[1] = (disp_val_q[15:4]  == 12'h000) && !disp_dp_q[1];
`else
      blank = 4'b0000;
`endif

      active        = (presc_q >= GUARD) && !blank[idx_q];
      an_d          = 4'b1111;
      if (active) an_d[idx_q] = 1'b0;
      dp_d          = active ? ~disp_dp_q[idx_q] : 1'b1;
      hex_digit_d   = disp_val_q[{idx_q, 2'b00} +: 4];
      frame_start_d = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q       <= '0;
         idx_q         <= 2'd0;
         pend_val_q    <= 16'h0000;
         pend_dp_q     <= 4'h0;
         pend_flag_q   <= 1'b0;
         disp_val_q    <= 16'h0000;
         disp_dp_q     <= 4'h0;
         hex_digit_q   <= 4'h0;
         an_q          <= 4'b1111;
         dp_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         presc_q       <= presc_d;
         idx_q         <= idx_d;
         pend_val_q    <= pend_val_d;
         pend_dp_q     <= pend_dp_d;
         pend_flag_q   <= pend_flag_d;
         disp_val_q    <= disp_val_d;
         disp_dp_q     <= disp_dp_d;
         hex_digit_q   <= hex_digit_d;
         an_q          <= an_d;
         dp_q          <= dp_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hex_digit   = hex_digit_q;
   assign an          = an_q;
   assign dp          = dp_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - directed table-driven bench for seg_scan_mux (REFRESH_DIV=4, GUARD_CYCLES=2)
module tb_seg_scan_mux;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0]  dp_in = 4'h0;
   logic        load = 1'b0;
   logic [3:0]  hex_digit;
   logic [3:0]  an;
   logic        dp;
   logic        frame_start;

   always #5 clk = ~clk;

   seg_scan_mux #(.REFRESH_DIV(4), .GUARD_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp_in       (dp_in),
      .load        (load),
      .hex_digit   (hex_digit),
      .an          (an),
      .dp          (dp),
      .frame_start (frame_start)
   );

   typedef struct {
      int         cyc;
      bit         ld;
      logic [15:0] val;
      logic [3:0] dpi;
      bit         chk;
      logic [3:0] an;
      logic [3:0] hex;
      logic       dp;
      logic       fs;
   } vec_t;

   vec_t tbl[$];
   int   k = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   bit   mon_en = 1'b0;
   int   cnt_e = 0, cnt_d = 0, cnt_b = 0, cnt_7 = 0, cnt_off = 0, cnt_bad = 0;
   int   bad_hex2 = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      k++;
      @(negedge clk);
   endtask

   task automatic run_to(input int n);
      while (k < n) tick();
   endtask

   function automatic logic [3:0] lz(input logic [3:0] a);
      return LZB ? 4'b1111 : a;
   endfunction

   function automatic vec_t v(input int c, input bit ld, input logic [15:0] val, input logic [3:0] dpi,
                              input bit chk, input logic [3:0] a, input logic [3:0] h, input logic d,
                              input logic f);
      vec_t r;
      r.cyc = c; r.ld = ld; r.val = val; r.dpi = dpi; r.chk = chk;
      r.an = a; r.hex = h; r.dp = d; r.fs = f;
      return r;
   endfunction

   // Anode histogram over the first frame, and the "1111 never shows" window.
   always @(negedge clk) begin
      if (mon_en && k >= 1 && k <= 64) begin
         case (an)
            4'b1110: cnt_e   <= cnt_e + 1;
            4'b1101: cnt_d   <= cnt_d + 1;
            4'b1011: cnt_b   <= cnt_b + 1;
            4'b0111: cnt_7   <= cnt_7 + 1;
            4'b1111: cnt_off <= cnt_off + 1;
            default: cnt_bad <= cnt_bad + 1;
         endcase
      end
      if (mon_en && k >= 193 && k <= 256 && hex_digit !== 4'h2) bad_hex2 <= bad_hex2 + 1;
   end

   initial begin
      // k = edges since reset release; outputs after edge k reflect state after edge k-1.
      tbl.push_back(v(  1, 0, 16'h0, 4'h0, 1, 4'b1111,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v(  2, 0, 16'h0, 4'h0, 1, 4'b1111,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v(  3, 0, 16'h0, 4'h0, 1, 4'b1110,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 16, 0, 16'h0, 4'h0, 1, 4'b1110,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 17, 0, 16'h0, 4'h0, 1, 4'b1111,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 18, 0, 16'h0, 4'h0, 1, 4'b1111,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 19, 0, 16'h0, 4'h0, 1, lz(4'b1101), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 35, 0, 16'h0, 4'h0, 1, lz(4'b1011), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 51, 0, 16'h0, 4'h0, 1, lz(4'b0111), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 64, 0, 16'h0, 4'h0, 1, lz(4'b0111), 4'h0, 1'b1, 1'b1));
      tbl.push_back(v( 65, 0, 16'h0, 4'h0, 1, 4'b1111,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 67, 0, 16'h0, 4'h0, 1, 4'b1110,     4'h0, 1'b1, 1'b0));
      tbl.push_back(v( 80, 1, 16'h1A3F, 4'b0100, 1, 4'b1110, 4'h0, 1'b1, 1'b0));
      tbl.push_back(v(100, 0, 16'h0, 4'h0, 1, lz(4'b1011), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v(127, 0, 16'h0, 4'h0, 1, lz(4'b0111), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v(128, 0, 16'h0, 4'h0, 1, lz(4'b0111), 4'h0, 1'b1, 1'b1));
      tbl.push_back(v(129, 0, 16'h0, 4'h0, 1, 4'b1111, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(131, 0, 16'h0, 4'h0, 1, 4'b1110, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(140, 1, 16'h1111, 4'h0, 0, 4'b0000, 4'h0, 1'b0, 1'b0));
      tbl.push_back(v(147, 0, 16'h0, 4'h0, 1, 4'b1101, 4'h3, 1'b1, 1'b0));
      tbl.push_back(v(150, 1, 16'h2222, 4'h0, 0, 4'b0000, 4'h0, 1'b0, 1'b0));
      tbl.push_back(v(161, 0, 16'h0, 4'h0, 1, 4'b1111, 4'hA, 1'b1, 1'b0));
      tbl.push_back(v(163, 0, 16'h0, 4'h0, 1, 4'b1011, 4'hA, 1'b0, 1'b0));
      tbl.push_back(v(179, 0, 16'h0, 4'h0, 1, 4'b0111, 4'h1, 1'b1, 1'b0));
      tbl.push_back(v(192, 0, 16'h0, 4'h0, 1, 4'b0111, 4'h1, 1'b1, 1'b1));
      tbl.push_back(v(195, 0, 16'h0, 4'h0, 1, 4'b1110, 4'h2, 1'b1, 1'b0));
      tbl.push_back(v(211, 0, 16'h0, 4'h0, 1, 4'b1101, 4'h2, 1'b1, 1'b0));
      tbl.push_back(v(227, 0, 16'h0, 4'h0, 1, 4'b1011, 4'h2, 1'b1, 1'b0));
      tbl.push_back(v(243, 0, 16'h0, 4'h0, 1, 4'b0111, 4'h2, 1'b1, 1'b0));
      tbl.push_back(v(256, 1, 16'hBEEF, 4'h0, 1, 4'b0111, 4'h2, 1'b1, 1'b1));
      tbl.push_back(v(257, 0, 16'h0, 4'h0, 1, 4'b1111, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(259, 0, 16'h0, 4'h0, 1, 4'b1110, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(275, 0, 16'h0, 4'h0, 1, 4'b1101, 4'hE, 1'b1, 1'b0));
      tbl.push_back(v(291, 0, 16'h0, 4'h0, 1, 4'b1011, 4'hE, 1'b1, 1'b0));
      tbl.push_back(v(307, 0, 16'h0, 4'h0, 1, 4'b0111, 4'hB, 1'b1, 1'b0));
      tbl.push_back(v(323, 0, 16'h0, 4'h0, 1, 4'b1110, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(330, 1, 16'h0042, 4'h0, 1, 4'b1110, 4'hF, 1'b1, 1'b0));
      tbl.push_back(v(371, 0, 16'h0, 4'h0, 1, 4'b0111, 4'hB, 1'b1, 1'b0));
      tbl.push_back(v(387, 0, 16'h0, 4'h0, 1, 4'b1110, 4'h2, 1'b1, 1'b0));
      tbl.push_back(v(403, 0, 16'h0, 4'h0, 1, 4'b1101, 4'h4, 1'b1, 1'b0));
      tbl.push_back(v(419, 0, 16'h0, 4'h0, 1, lz(4'b1011), 4'h0, 1'b1, 1'b0));
      tbl.push_back(v(435, 0, 16'h0, 4'h0, 1, lz(4'b0111), 4'h0, 1'b1, 1'b0));

      repeat (3) @(negedge clk);
      check("reset an", an, 4'b1111);
      check("reset dp", dp, 1'b1);
      check("reset hex_digit", hex_digit, 4'h0);
      check("reset frame_start", frame_start, 1'b0);
      rst_n  = 1'b1;
      k      = 0;
      mon_en = 1'b1;

      foreach (tbl[i]) begin
         run_to(tbl[i].cyc - 1);
         if (tbl[i].ld) begin
            load  = 1'b1;
            value = tbl[i].val;
            dp_in = tbl[i].dpi;
         end
         tick();
         load = 1'b0;
         if (tbl[i].chk) begin
            check($sformatf("k%0d an", tbl[i].cyc), an, tbl[i].an);
            check($sformatf("k%0d hex_digit", tbl[i].cyc), hex_digit, tbl[i].hex);
            check($sformatf("k%0d dp", tbl[i].cyc), dp, tbl[i].dp);
            check($sformatf("k%0d frame_start", tbl[i].cyc), frame_start, tbl[i].fs);
         end
         if (tbl[i].cyc == 257) check("pend_flag after wrap load", dut.pend_flag_q, 1'b0);
      end

      check("frame0 an=1110 count", cnt_e, 14);
      check("frame0 an=1101 count", cnt_d, LZB ? 0 : 14);
      check("frame0 an=1011 count", cnt_b, LZB ? 0 : 14);
      check("frame0 an=0111 count", cnt_7, LZB ? 0 : 14);
      check("frame0 an=1111 count", cnt_off, LZB ? 50 : 8);
      check("frame0 illegal an count", cnt_bad, 0);
      check("overwritten load leaked", bad_hex2, 0);

      // Pending load, then a one-clock reset pulse in the middle of digit 2.
      mon_en = 1'b0;
      run_to(449);
      load  = 1'b1;
      value = 16'h1234;
      dp_in = 4'hF;
      tick();
      load = 1'b0;
      run_to(485);
      check("pend_flag before reset", dut.pend_flag_q, 1'b1);
      rst_n = 1'b0;
      #1;
      check("mid reset an", an, 4'b1111);
      check("mid reset dp", dp, 1'b1);
      check("mid reset hex_digit", hex_digit, 4'h0);
      check("mid reset frame_start", frame_start, 1'b0);
      check("mid reset pend_flag", dut.pend_flag_q, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      k     = 0;
      run_to(1);
      check("post reset k1 an", an, 4'b1111);
      run_to(3);
      check("post reset k3 an", an, 4'b1110);
      check("post reset k3 hex", hex_digit, 4'h0);
      run_to(64);
      check("post reset k64 frame_start", frame_start, 1'b1);
      check("post reset k64 an", an, lz(4'b0111));
      run_to(67);
      check("post reset k67 an", an, 4'b1110);
      check("post reset k67 hex", hex_digit, 4'h0);
      check("post reset k67 dp", dp, 1'b1);
      run_to(115);
      check("post reset k115 an", an, lz(4'b0111));
      check("post reset k115 hex", hex_digit, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
